// File: rtl/ac_axis_in_buf_if.sv
// Stream-in and upsp read-port bundle for ac_axis_in_buf.
// The slave modport is the buffer's view; master is the producer/consumer side.
interface ac_axis_in_buf_if #(
    parameter int DATA_WIDTH = 32
);
    logic                    axis_tvalid;
    logic                    axis_tready;
    logic [DATA_WIDTH-1:0]   axis_tdata;
    logic [DATA_WIDTH/8-1:0] axis_tkeep;
    logic                    axis_tlast;
    logic                    axis_user;
    logic                    upsp_ac_rd;
    logic                    ac_upsp_rvalid;
    logic [DATA_WIDTH-1:0]   ac_upsp_rdata;

    modport slave (
        input  axis_tvalid, axis_tdata, axis_tkeep, axis_tlast, axis_user, upsp_ac_rd,
        output axis_tready, ac_upsp_rvalid, ac_upsp_rdata
    );

    modport master (
        output axis_tvalid, axis_tdata, axis_tkeep, axis_tlast, axis_user, upsp_ac_rd,
        input  axis_tready, ac_upsp_rvalid, ac_upsp_rdata
    );
endinterface

// File: rtl/ac_axis_in_buf.sv
// Input access-control stage: frames AXI-Stream beats on SOF/tlast into a FIFO and
// serves upsp read requests with a fixed one-cycle latency, flagging framing errors.
module ac_axis_in_buf #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int UPSP_DATA_WIDTH = 32,
    parameter int CRF_DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [CRF_DATA_WIDTH-1:0]     frame_len,
    ac_axis_in_buf_if.slave               bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          frame_err,
    output logic                          in_frame_done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, WAIT_SOF, RUN, DRAIN} state_t;

    state_t                     state, state_n;
    logic [CRF_DATA_WIDTH-1:0]  len_q, len_n;
    logic [CRF_DATA_WIDTH-1:0]  beat_cnt, beat_cnt_n;
    logic                       err_n;
    logic                       tready;
    logic                       push, pop, full, empty, keep_ok, is_last;

    logic [AXIS_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic                       rvalid_q;
    logic [UPSP_DATA_WIDTH-1:0] rdata_q;

    assign full    = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign empty   = (fifo_cnt == '0);
    assign pop     = bus.upsp_ac_rd & ~empty;
    assign keep_ok = &bus.axis_tkeep;
    assign is_last = (beat_cnt == len_q - CRF_DATA_WIDTH'(1));

    assign bus.axis_tready    = tready;
    assign bus.ac_upsp_rvalid = rvalid_q;
    assign bus.ac_upsp_rdata  = rdata_q;

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_n       = state;
        len_n         = len_q;
        beat_cnt_n    = beat_cnt;
        err_n         = frame_err;
        tready        = 1'b0;
        push          = 1'b0;
        in_frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = WAIT_SOF;
                    len_n      = frame_len;
                    beat_cnt_n = '0;
                    err_n      = 1'b0;
                end
            end
            WAIT_SOF: begin
                tready = 1'b1;
                if (bus.axis_tvalid) begin
                    if (!keep_ok) err_n = 1'b1;
                    // Beats before the SOF marker are consumed but never stored.
                    if (bus.axis_user) begin
                        push       = 1'b1;
                        beat_cnt_n = CRF_DATA_WIDTH'(1);
                        if (len_q == CRF_DATA_WIDTH'(1)) begin
                            state_n = DRAIN;
                            if (!bus.axis_tlast) err_n = 1'b1;
                        end else if (bus.axis_tlast) begin
                            state_n = DRAIN;
                            err_n   = 1'b1;
                        end else begin
                            state_n = RUN;
                        end
                    end
                end
            end
            RUN: begin
                tready = ~full;
                if (bus.axis_tvalid && !full) begin
                    push       = 1'b1;
                    beat_cnt_n = beat_cnt + CRF_DATA_WIDTH'(1);
                    if (!keep_ok || bus.axis_user) err_n = 1'b1;
                    if (is_last) begin
                        state_n = DRAIN;
                        if (!bus.axis_tlast) err_n = 1'b1;
                    end else if (bus.axis_tlast) begin
                        state_n = DRAIN;
                        err_n   = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Done only once the final read has been presented to upsp.
                if (empty && !rvalid_q) begin
                    in_frame_done = 1'b1;
                    state_n       = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            len_q     <= '0;
            beat_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            len_q     <= len_n;
            beat_cnt  <= beat_cnt_n;
            frame_err <= err_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= pop;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                rdata_q <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // NOTE: storage has no reset; occupancy and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.axis_tdata;
    end
endmodule

// File: tb/tb_ac_axis_in_buf.sv
// Randomized scoreboard bench for ac_axis_in_buf: frames are planned as beat lists,
// expected stored data is queued up front and a monitor checks every read response.
module tb_ac_axis_in_buf;
    localparam int DW    = 32;
    localparam int CW    = 32;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CW-1:0]    frame_len;
    logic [CNT_W-1:0] fifo_cnt;
    logic             frame_err;
    logic             in_frame_done;

    ac_axis_in_buf_if #(.DATA_WIDTH(DW)) bus ();

    ac_axis_in_buf #(
        .AXIS_DATA_WIDTH(DW), .UPSP_DATA_WIDTH(DW), .CRF_DATA_WIDTH(CW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .bus(bus),
        .fifo_cnt(fifo_cnt), .frame_err(frame_err), .in_frame_done(in_frame_done)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    int            done_seen = 0;
    int            frames_exp = 0;
    int            rd_mode = 0;     // 0 none, 1 random, 2 every cycle
    bit            rd_force = 1'b0;
    bit            rand_bit = 1'b0;
    bit            gaps = 1'b0;
    bit            drv_done = 1'b0;
    bit            err_a, err_b;
    logic [DW-1:0] exp_q[$];

    assign bus.upsp_ac_rd = rd_force | (rd_mode == 2) | ((rd_mode == 1) & rand_bit);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        rand_bit = 1'($urandom_range(0, 1));
    end

    // Monitor: every presented read is compared against the head of the scoreboard.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (in_frame_done) done_seen++;
                if (bus.ac_upsp_rvalid) begin
                    if (exp_q.size() == 0) check("unexpected_rvalid", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("rdata", bus.ac_upsp_rdata, e);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic send_beat(input logic [DW-1:0] d, input bit u, input bit l,
                             input logic [DW/8-1:0] k);
        int t = 0;
        while (gaps && $urandom_range(0, 3) == 0) begin
            bus.axis_tvalid = 1'b0;
            @(negedge clk);
        end
        bus.axis_tvalid = 1'b1;
        bus.axis_tdata  = d;
        bus.axis_user   = u;
        bus.axis_tlast  = l;
        bus.axis_tkeep  = k;
        while (!bus.axis_tready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!bus.axis_tready) check("tready_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic pulse_start(input int len);
        @(negedge clk);
        start     = 1'b1;
        frame_len = CW'(len);
        @(negedge clk);
        start     = 1'b0;
        check("err_cleared_on_start", frame_err, 0);
    endtask

    // nb = body beats actually sent (nb < len means tlast arrives early).
    task automatic run_frame(input int len, input int junk, input int nb, input int bad_user,
                             input int bad_keep, input bit drop_last, output bit exp_err);
        logic [DW-1:0] d;
        bit            u, l;
        exp_err = (nb < len) || (bad_user > 0) || (bad_keep >= 0) || (drop_last && nb == len);
        pulse_start(len);
        for (int i = 0; i < junk; i++) send_beat(DW'(32'hA + i), 1'b0, 1'b0, '1);
        for (int i = 0; i < nb; i++) begin
            d = $urandom;
            exp_q.push_back(d);
            u = (i == 0) || (bad_user > 0 && i == bad_user);
            l = (i == nb - 1) && !(drop_last && nb == len);
            send_beat(d, u, l, (i == bad_keep) ? 4'b0111 : 4'hF);
        end
        bus.axis_tvalid = 1'b0;
    endtask

    task automatic wait_done(input bit exp_err);
        int t = 0;
        frames_exp++;
        while (done_seen < frames_exp && t < 3000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("done_pulse_count", done_seen, frames_exp);
        check("frame_err", frame_err, exp_err);
        check("scoreboard_drained", exp_q.size(), 0);
        check("idle_tready", bus.axis_tready, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tready"}, bus.axis_tready, 0);
        check({tag, "_rvalid"}, bus.ac_upsp_rvalid, 0);
        check({tag, "_rdata"}, bus.ac_upsp_rdata, 0);
        check({tag, "_fifo_cnt"}, fifo_cnt, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_done"}, in_frame_done, 0);
    endtask

    initial begin
        int t, len, nb, bu, bk;
        bit dl;
        rst = 1'b1; start = 1'b0; frame_len = '0;
        bus.axis_tvalid = 1'b0; bus.axis_tdata = '0; bus.axis_tkeep = '1;
        bus.axis_tlast = 1'b0; bus.axis_user = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Clean 8-beat frame, reads every cycle.
        rd_mode = 2;
        run_frame(8, 0, 8, 0, -1, 1'b0, err_a);
        wait_done(err_a);

        // Three pre-SOF beats are dropped.
        run_frame(8, 3, 8, 0, -1, 1'b0, err_a);
        wait_done(err_a);

        // Early tlast on beat 5 truncates the frame; next start clears the error.
        run_frame(8, 0, 5, 0, -1, 1'b0, err_a);
        wait_done(err_a);

        // Backpressure: 20-beat frame against a 16-entry FIFO with no reads.
        rd_mode  = 0;
        drv_done = 1'b0;
        fork
            begin
                run_frame(20, 0, 20, 0, -1, 1'b0, err_b);
                drv_done = 1'b1;
            end
        join_none
        t = 0;
        while (fifo_cnt != CNT_W'(DEPTH) && t < 500) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        check("full_cnt", fifo_cnt, DEPTH);
        check("full_tready", bus.axis_tready, 0);
        rd_force = 1'b1;
        repeat (4) @(negedge clk);
        rd_force = 1'b0;
        t = 0;
        while (!drv_done && t < 500) begin @(negedge clk); t++; end
        check("refill_cnt", fifo_cnt, DEPTH);
        rd_mode = 2;
        wait_done(err_b);

        // Read while empty is ignored.
        rd_mode  = 0;
        @(negedge clk);
        rd_force = 1'b1;
        @(negedge clk);
        rd_force = 1'b0;
        check("empty_rd_rvalid", bus.ac_upsp_rvalid, 0);
        check("empty_rd_cnt", fifo_cnt, 0);

        // Simultaneous push and pop at occupancy 3.
        pulse_start(4);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(DW'(32'h100 + i));
            send_beat(DW'(32'h100 + i), i == 0, 1'b0, '1);
        end
        check("pre_pushpop_cnt", fifo_cnt, 3);
        exp_q.push_back(32'h103);
        rd_force = 1'b1;
        send_beat(32'h103, 1'b0, 1'b1, '1);
        rd_force = 1'b0;
        bus.axis_tvalid = 1'b0;
        check("pushpop_cnt", fifo_cnt, 3);
        check("pushpop_rvalid", bus.ac_upsp_rvalid, 1);
        rd_mode = 2;
        wait_done(1'b0);

        // Reset in the middle of a frame with six beats buffered.
        rd_mode = 0;
        pulse_start(10);
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(DW'(32'h200 + i));
            send_beat(DW'(32'h200 + i), i == 0, 1'b0, '1);
        end
        check("prereset_cnt", fifo_cnt, 6);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        exp_q.delete();
        bus.axis_tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_tready", bus.axis_tready, 0);

        // Randomized frames with mixed framing faults.
        repeat (15) begin
            len = $urandom_range(1, 24);
            nb  = len;
            if (len > 2 && $urandom_range(0, 3) == 0) nb = $urandom_range(2, len - 1);
            bu  = (nb > 1 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, nb - 1)) : 0;
            bk  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
            dl  = ($urandom_range(0, 5) == 0);
            gaps    = 1'($urandom_range(0, 1));
            rd_mode = $urandom_range(1, 2);
            run_frame(len, $urandom_range(0, 3), nb, bu, bk, dl, err_a);
            wait_done(err_a);
        end

        repeat (5) @(negedge clk);
        check("final_done_count", done_seen, frames_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
